// File: rtl/rv32i_pkg.sv
// Shared rv32i core types: datapath width, register address width and
// the payloads carried on the register-file write path.
package rv32i_pkg;

    localparam int unsigned DPW    = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DPW-1:0]    data;
    } wb_req_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [DPW-1:0]    data;
    } lu_entry_t;

endpackage

// File: rtl/wb_lu_buffer.sv
// Parking FIFO for long-latency unit results. Each entry has its own valid
// bit so a younger W write can kill it in place (CAM match on rd); killed
// entries still occupy their slot until they reach the head and are popped.
// Optional: WB_PORT_ARBITER_SCOREBOARD_EN adds a registered pending_mask_o.
module wb_lu_buffer
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 push_i,
    input  logic [REG_AW-1:0]                    push_rd_i,
    input  logic [DPW-1:0]                       push_data_i,
    input  logic                                 pop_i,
    input  logic                                 kill_i,
    input  logic [REG_AW-1:0]                    kill_rd_i,
    output lu_entry_t                            head_o,
    output logic [$clog2(DEPTH + 1)-1:0]         count_o
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
    ,
    output logic [NREGS-1:0]                     pending_mask_o
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    lu_entry_t       mem_q [DEPTH];
    lu_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Next buffer state: kill, then pop, then push (push never lands on the popped slot)
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (kill_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].rd == kill_rd_i) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end
        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + PW'(1);
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    // Buffer state registers; reset drops all parked results
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
    logic [NREGS-1:0] mask_d, mask_q;

    // Registers targeted by live parked entries, taken from the next buffer state
    always_comb begin
        mask_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_d[i].valid) begin
                mask_d[mem_d[i].rd] = 1'b1;
            end
        end
        mask_d[0] = 1'b0;
    end

    // Pending-register mask register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign pending_mask_o = mask_q;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: W stage has priority, LU results are
// written directly when the port is free or parked in wb_lu_buffer.
// A wait counter on the buffer head requests a one-cycle W bubble.
// Optional: WB_PORT_ARBITER_SCOREBOARD_EN exposes pending_mask.
module wb_port_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [DPW-1:0]    resultW,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [DPW-1:0]    lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [DPW-1:0]    rf_wdata,
    output logic              stall_req
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
    ,
    output logic [NREGS-1:0]  pending_mask
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = 4;

    lu_entry_t       head;
    logic [CW-1:0]   count;
    logic            w_wr_c, nonempty_c, accept_c, pop_c, head_wr_c, direct_c, push_c;
    wb_req_t         port_c;
    logic [WW-1:0]   wait_q, wait_d;
    logic            stall_q, stall_d;

    // Port selection and buffer control
    always_comb begin
        w_wr_c     = regwriteW && (RdW != '0);
        nonempty_c = (count != '0);
        lu_ready   = !rst && (count < CW'(DEPTH));
        accept_c   = lu_valid && lu_ready;
        // Any head (live or killed) leaves whenever W does not own the port
        pop_c      = nonempty_c && !w_wr_c && !rst;
        head_wr_c  = pop_c && head.valid;
        // A killed head does not block a direct write, but the result is still parked
        direct_c   = !w_wr_c && accept_c && (lu_rd != '0) && (!nonempty_c || !head.valid);
        push_c     = accept_c && (lu_rd != '0) && (nonempty_c || w_wr_c)
                     && !(w_wr_c && (lu_rd == RdW));
        port_c     = '0;
        if (rst) begin
            port_c = '0;
        end else if (w_wr_c) begin
            port_c = '{we: 1'b1, rd: RdW, data: resultW};
        end else if (head_wr_c) begin
            port_c = '{we: 1'b1, rd: head.rd, data: head.data};
        end else if (direct_c) begin
            port_c = '{we: 1'b1, rd: lu_rd, data: lu_data};
        end
    end

    assign rf_we    = port_c.we;
    assign rf_rd    = port_c.rd;
    assign rf_wdata = port_c.data;

    // Head wait counter and one-cycle bubble request
    always_comb begin
        wait_d = '0;
        if (!stall_q && nonempty_c && head.valid && !pop_c) begin
            wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
        end
        stall_d = (wait_d == WW'(MAX_WAIT));
    end

    // Wait counter and stall request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign stall_req = stall_q;

    wb_lu_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i          (clk),
        .rst_i          (rst),
        .push_i         (push_c),
        .push_rd_i      (lu_rd),
        .push_data_i    (lu_data),
        .pop_i          (pop_c),
        .kill_i         (w_wr_c),
        .kill_rd_i      (RdW),
        .head_o         (head),
        .count_o        (count)
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
        ,
        .pending_mask_o (pending_mask)
`endif
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst, regwriteW, lu_valid;
    logic [4:0]  RdW, lu_rd;
    logic [31:0] resultW, lu_data;
    logic        lu_ready, rf_we, stall_req;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
    logic [31:0] pending_mask;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .regwriteW (regwriteW),
        .RdW       (RdW),
        .resultW   (resultW),
        .lu_valid  (lu_valid),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .stall_req (stall_req)
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
        ,
        .pending_mask (pending_mask)
`endif
    );

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
    } ment_t;

    ment_t       mq[$];
    int          m_wait = 0;
    bit          m_stall = 1'b0;
    bit [31:0]   m_rf[32];
    bit [31:0]   dut_rf[32];
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        obs_we, obs_rdy, obs_stall;
    logic [4:0]  obs_rd;
    logic [31:0] obs_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cyc(input logic r, input logic we, input logic [4:0] rdw, input logic [31:0] rw,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        bit        wwr, had, e_rdy, acc, dir, e_we, waiting;
        bit [4:0]  e_rd;
        bit [31:0] e_d;
        bit [31:0] e_mask;
        rst = r; regwriteW = we; RdW = rdw; resultW = rw;
        lu_valid = lv; lu_rd = lr; lu_data = ld;
        #3;
        obs_we = rf_we; obs_rd = rf_rd; obs_data = rf_wdata;
        obs_rdy = lu_ready; obs_stall = stall_req;

        had   = (mq.size() > 0);
        wwr   = we && (rdw != 5'd0);
        e_rdy = !r && (mq.size() < int'(DEPTH));
        acc   = lv && e_rdy;
        e_we = 1'b0; e_rd = '0; e_d = '0; dir = 1'b0;
        if (!r) begin
            if (wwr) begin
                e_we = 1'b1; e_rd = rdw; e_d = rw;
            end else if (had && mq[0].v) begin
                e_we = 1'b1; e_rd = mq[0].rd; e_d = mq[0].d;
            end else if (acc && lr != 5'd0) begin
                dir = 1'b1; e_we = 1'b1; e_rd = lr; e_d = ld;
            end
        end
        chk("rf_we", obs_we, e_we);
        if (e_we) begin
            chk("rf_rd", obs_rd, e_rd);
            chk("rf_wdata", obs_data, e_d);
        end
        chk("lu_ready", obs_rdy, e_rdy);
        chk("stall_req", obs_stall, m_stall);
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
        e_mask = '0;
        foreach (mq[j]) if (mq[j].v) e_mask = e_mask | (32'd1 << mq[j].rd);
        e_mask[0] = 1'b0;
        chk("pending_mask", pending_mask, e_mask);
`else
        e_mask = '0;
`endif
        if (obs_we === 1'b1) dut_rf[obs_rd] = obs_data;
        if (e_we) m_rf[e_rd] = e_d;

        if (r) begin
            mq.delete();
            m_wait  = 0;
            m_stall = 1'b0;
        end else begin
            waiting = had && mq[0].v && wwr;
            if (had && !wwr) mq.delete(0);
            if (wwr) foreach (mq[j]) if (mq[j].rd == rdw) mq[j].v = 1'b0;
            if (acc && lr != 5'd0 && !(wwr && lr == rdw) && (!dir || had))
                mq.push_back('{1'b1, lr, ld});
            if (m_stall) m_wait = 0;
            else if (waiting) m_wait = (m_wait < int'(MAX_WAIT)) ? m_wait + 1 : int'(MAX_WAIT);
            else m_wait = 0;
            m_stall = (m_wait == int'(MAX_WAIT));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int pulses, pulse_k;
        logic [4:0]  bub_rd;
        logic [31:0] bub_d;
        bit r, we, lv;

        rst = 1'b1; regwriteW = 1'b0; RdW = '0; resultW = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd1);
        chk("rst_ready", obs_rdy, 1'b0);
        chk("rst_we", obs_we, 1'b0);

        // Idle port: direct zero-latency LU write
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
        chk("idle_we", obs_we, 1'b1);
        chk("idle_rd", obs_rd, 5'd7);
        chk("idle_data", obs_data, 32'h55);
        idle();
        chk("idle_empty_we", obs_we, 1'b0);

        // Conflict: W first, parked LU result next cycle
        cyc(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'hB);
        chk("conf_rd0", obs_rd, 5'd3);
        chk("conf_d0", obs_data, 32'hA);
        idle();
        chk("conf_we1", obs_we, 1'b1);
        chk("conf_rd1", obs_rd, 5'd9);
        chk("conf_d1", obs_data, 32'hB);

        // Full buffer back-pressure
        cyc(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'h10);
        cyc(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'h11);
        chk("full_rdy_last", obs_rdy, 1'b1);
        cyc(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'h12);
        chk("full_rdy0", obs_rdy, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12);
        chk("full_pop_rdy", obs_rdy, 1'b0);
        chk("full_pop_rd", obs_rd, 5'd10);
        cyc(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd12, 32'h12);
        chk("full_rdy_back", obs_rdy, 1'b1);
        for (int i = 0; i < 4; i++) idle();

        // WAW kill of a parked x5
        cyc(1'b0, 1'b1, 5'd1, 32'h7, 1'b1, 5'd5, 32'h1);
        cyc(1'b0, 1'b1, 5'd5, 32'h2, 1'b0, 5'd0, 32'h0);
        idle();
        chk("waw_no_write", obs_we, 1'b0);
        idle();
        chk("waw_final_x5", dut_rf[5], 32'h2);

        // Starvation: exactly one bubble, five cycles after the push
        cyc(1'b0, 1'b1, 5'd1, 32'h111, 1'b1, 5'd6, 32'h66);
        pulses = 0; pulse_k = 0; bub_rd = '0; bub_d = '0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, !m_stall, 5'd2, 32'(k), 1'b0, 5'd0, 32'd0);
            if (obs_stall === 1'b1) begin
                pulses++; pulse_k = k; bub_rd = obs_rd; bub_d = obs_data;
            end
        end
        chk("stall_pulses", 32'(pulses), 32'd1);
        chk("stall_cycle", 32'(pulse_k), 32'd5);
        chk("bubble_rd", bub_rd, 5'd6);
        chk("bubble_data", bub_d, 32'h66);

        // x0 discard, then reset with two entries parked
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
        chk("x0_we", obs_we, 1'b0);
        chk("x0_rdy", obs_rdy, 1'b1);
        cyc(1'b0, 1'b1, 5'd1, 32'h21, 1'b1, 5'd13, 32'h13);
        cyc(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd14, 32'h14);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h15);
        chk("rstmid_rdy", obs_rdy, 1'b0);
        idle();
        chk("post_rst_we", obs_we, 1'b0);
        chk("post_rst_rdy", obs_rdy, 1'b1);
        chk("post_rst_stall", obs_stall, 1'b0);
`ifdef WB_PORT_ARBITER_SCOREBOARD_EN
        chk("post_rst_mask", pending_mask, 32'd0);
`endif

        // Random traffic on a small register set to exercise kills and x0
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            we = m_stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) < 65);
            lv = ($urandom_range(0, 99) < 55);
            cyc(r, we, 5'($urandom_range(0, 7)), $urandom, lv, 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 12; i++) idle();
        for (int i = 1; i < 32; i++) chk("rf_final", dut_rf[i], m_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
